// File: rtl/cmp_ctrl_pkg.sv
// Shared definitions for the MIX comparison controller slice: word geometry,
// opcode range, comparison-indicator encodings and sequencer states.
package cmp_ctrl_pkg;

    localparam int unsigned WORD_W    = 31;
    localparam int unsigned MAG_W     = WORD_W - 1;
    localparam int unsigned BYTE_W    = 6;
    localparam int unsigned NUM_BYTES = 5;

    localparam logic [5:0] OP_CMPA = 6'd56;
    localparam logic [5:0] OP_CMPX = 6'd63;

    localparam logic [1:0] CI_EQ = 2'b00;
    localparam logic [1:0] CI_LT = 2'b01;
    localparam logic [1:0] CI_GT = 2'b10;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FETCH,
        ST_EXTRACT,
        ST_COMPARE,
        ST_RESULT,
        ST_WB
    } state_e;

endpackage

// File: rtl/cmp.sv
// Sign-magnitude comparison datapath: result captured on cmp_start, held
// until cmp_stop. Zero magnitudes compare equal regardless of sign.
module cmp
    import cmp_ctrl_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cmp_start,
    input  logic              cmp_stop,
    input  logic [WORD_W-1:0] in1,
    input  logic [WORD_W-1:0] in2,
    output logic              greater,
    output logic              less
);

    logic greater_q, greater_d;
    logic less_q, less_d;
    logic s1, s2;
    logic gt, lt;

    // Compare in1 against in2 as signed values; -0 is treated as +0.
    always_comb begin
        s1 = in1[WORD_W-1] & (in1[MAG_W-1:0] != '0);
        s2 = in2[WORD_W-1] & (in2[MAG_W-1:0] != '0);
        gt = 1'b0;
        lt = 1'b0;
        if (s1 != s2) begin
            gt = ~s1;
            lt = s1;
        end else if (!s1) begin
            gt = in1[MAG_W-1:0] > in2[MAG_W-1:0];
            lt = in1[MAG_W-1:0] < in2[MAG_W-1:0];
        end else begin
            gt = in1[MAG_W-1:0] < in2[MAG_W-1:0];
            lt = in1[MAG_W-1:0] > in2[MAG_W-1:0];
        end
        greater_d = greater_q;
        less_d    = less_q;
        if (cmp_start) begin
            greater_d = gt;
            less_d    = lt;
        end else if (cmp_stop) begin
            greater_d = 1'b0;
            less_d    = 1'b0;
        end
    end

    // Result register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            greater_q <= 1'b0;
            less_q    <= 1'b0;
        end else begin
            greater_q <= greater_d;
            less_q    <= less_d;
        end
    end

    assign greater = greater_q;
    assign less    = less_q;

endmodule

// File: rtl/mix_field.sv
// Field extraction (L:R) from a MIX word: bytes max(L,1)..R right-justified,
// sign kept only when L=0. Purely combinational.
module mix_field
    import cmp_ctrl_pkg::*;
(
    input  logic [WORD_W-1:0] word,
    input  logic [2:0]        l,
    input  logic [2:0]        r,
    output logic [WORD_W-1:0] field
);

    logic [2:0]       lp;
    logic [MAG_W-1:0] keep;
    int unsigned      byte_no;

    // Mask the selected bytes in place, then shift byte R down to byte 5.
    always_comb begin
        lp      = (l == 3'd0) ? 3'd1 : l;
        keep    = '0;
        byte_no = 0;
        for (int unsigned j = 0; j < MAG_W; j++) begin
            byte_no = NUM_BYTES - j / BYTE_W;
            if (byte_no >= 32'(lp) && byte_no <= 32'(r)) begin
                keep[j] = 1'b1;
            end
        end
        field = '0;
        if (r <= 3'd5) begin
            field[MAG_W-1:0] = (word[MAG_W-1:0] & keep) >> (BYTE_W * (NUM_BYTES - 32'(r)));
        end
        field[WORD_W-1] = (l == 3'd0) ? word[WORD_W-1] : 1'b0;
    end

endmodule

// File: rtl/cmp_ctrl.sv
// Sequencer for MIX CMPA/CMP1-6/CMPX: fetches M and the register, extracts
// field (L:R) from both, runs the cmp datapath and owns the CI register.
module cmp_ctrl
    import cmp_ctrl_pkg::*;
#(
    parameter int unsigned ADDR_W = 12
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [5:0]        opcode,
    input  logic [5:0]        fspec,
    input  logic [ADDR_W-1:0] addr,
    output logic              busy,
    output logic              done,
    output logic              fault,
    output logic [2:0]        reg_sel,
    input  logic [WORD_W-1:0] reg_data,
    output logic              mem_rd,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic              mem_ack,
    input  logic [WORD_W-1:0] mem_data,
    output logic [1:0]        ci
);

    state_e              state_q, state_d;
    logic [2:0]          reg_sel_q, reg_sel_d;
    logic [2:0]          l_q, l_d;
    logic [2:0]          r_q, r_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic                fault_q, fault_d;
    logic [WORD_W-1:0]   reg_word_q, reg_word_d;
    logic [WORD_W-1:0]   mem_word_q, mem_word_d;
    logic [WORD_W-1:0]   op1_q, op1_d;
    logic [WORD_W-1:0]   op2_q, op2_d;
    logic [1:0]          ci_q, ci_d;

    logic [WORD_W-1:0]   reg_field, mem_field;
    logic                cmp_start, cmp_stop;
    logic                greater, less;
    logic                illegal;

    mix_field u_field_reg (
        .word  (reg_word_q),
        .l     (l_q),
        .r     (r_q),
        .field (reg_field)
    );

    mix_field u_field_mem (
        .word  (mem_word_q),
        .l     (l_q),
        .r     (r_q),
        .field (mem_field)
    );

    cmp u_cmp (
        .clk       (clk),
        .rst_n     (rst_n),
        .cmp_start (cmp_start),
        .cmp_stop  (cmp_stop),
        .in1       (op1_q),
        .in2       (op2_q),
        .greater   (greater),
        .less      (less)
    );

    assign illegal = (opcode < OP_CMPA) || (fspec[5:3] > fspec[2:0]) || (fspec[2:0] > 3'd5);

    // Next-state and datapath register updates for the command sequence.
    always_comb begin
        state_d    = state_q;
        reg_sel_d  = reg_sel_q;
        l_d        = l_q;
        r_d        = r_q;
        addr_d     = addr_q;
        fault_d    = fault_q;
        reg_word_d = reg_word_q;
        mem_word_d = mem_word_q;
        op1_d      = op1_q;
        op2_d      = op2_q;
        ci_d       = ci_q;
        cmp_start  = 1'b0;
        cmp_stop   = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (start) begin
                    reg_sel_d = opcode[2:0];
                    l_d       = fspec[5:3];
                    r_d       = fspec[2:0];
                    addr_d    = addr;
                    fault_d   = illegal;
                    state_d   = illegal ? ST_WB : ST_FETCH;
                end
            end
            ST_FETCH: begin
                if (mem_ack) begin
                    mem_word_d = mem_data;
                    reg_word_d = reg_data;
                    state_d    = ST_EXTRACT;
                end
            end
            ST_EXTRACT: begin
                op1_d   = reg_field;
                op2_d   = mem_field;
                state_d = ST_COMPARE;
            end
            ST_COMPARE: begin
                cmp_start = 1'b1;
                state_d   = ST_RESULT;
            end
            ST_RESULT: begin
                cmp_stop = 1'b1;
                ci_d     = greater ? CI_GT : (less ? CI_LT : CI_EQ);
                state_d  = ST_WB;
            end
            ST_WB: begin
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State and operand registers; reset aborts any command in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            reg_sel_q  <= '0;
            l_q        <= '0;
            r_q        <= '0;
            addr_q     <= '0;
            fault_q    <= 1'b0;
            reg_word_q <= '0;
            mem_word_q <= '0;
            op1_q      <= '0;
            op2_q      <= '0;
            ci_q       <= CI_EQ;
        end else begin
            state_q    <= state_d;
            reg_sel_q  <= reg_sel_d;
            l_q        <= l_d;
            r_q        <= r_d;
            addr_q     <= addr_d;
            fault_q    <= fault_d;
            reg_word_q <= reg_word_d;
            mem_word_q <= mem_word_d;
            op1_q      <= op1_d;
            op2_q      <= op2_d;
            ci_q       <= ci_d;
        end
    end

    assign busy     = (state_q != ST_IDLE);
    assign done     = (state_q == ST_WB);
    assign fault    = (state_q == ST_WB) && fault_q;
    assign mem_rd   = (state_q == ST_FETCH);
    assign mem_addr = addr_q;
    assign reg_sel  = reg_sel_q;
    assign ci       = ci_q;

endmodule

// File: tb/tb_cmp_ctrl.sv
// Self-checking bench for cmp_ctrl: register file and memory are modelled
// here; expected CI comes from integer field values computed per command.
module tb_cmp_ctrl;

    localparam int unsigned AW = 12;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          start;
    logic [5:0]    opcode;
    logic [5:0]    fspec;
    logic [AW-1:0] addr;
    logic          busy, done, fault, mem_rd, mem_ack;
    logic [2:0]    reg_sel;
    logic [30:0]   reg_data, mem_data;
    logic [AW-1:0] mem_addr;
    logic [1:0]    ci;

    logic [30:0]   regs [8];
    logic [30:0]   mem  [4096];
    int            ack_delay;
    int            tests_run;
    int            tests_failed;
    logic [1:0]    exp_ci;

    cmp_ctrl #(.ADDR_W(AW)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .opcode(opcode),
        .fspec(fspec), .addr(addr), .busy(busy), .done(done), .fault(fault),
        .reg_sel(reg_sel), .reg_data(reg_data), .mem_rd(mem_rd),
        .mem_addr(mem_addr), .mem_ack(mem_ack), .mem_data(mem_data), .ci(ci)
    );

    always #5 clk = ~clk;

    // Index registers only carry bytes 4-5 and the sign.
    function automatic logic [30:0] rview(input int sel);
        logic [30:0] w;
        w = regs[sel];
        if (sel >= 1 && sel <= 6) w[29:12] = '0;
        return w;
    endfunction

    assign reg_data = rview(int'(reg_sel));

    // Memory responder: acks after ack_delay extra cycles of mem_rd.
    initial begin
        int cnt;
        cnt = 0;
        mem_ack = 1'b0;
        mem_data = '0;
        forever begin
            @(negedge clk);
            mem_ack = 1'b0;
            if (mem_rd) begin
                if (cnt >= ack_delay) begin
                    mem_ack = 1'b1;
                    mem_data = mem[mem_addr];
                    cnt = 0;
                end else begin
                    cnt++;
                end
            end else begin
                cnt = 0;
            end
        end
    end

    function automatic longint field_val(input logic [30:0] w, input int l, input int r);
        int lp;
        longint mag;
        lp  = (l < 1) ? 1 : l;
        mag = longint'(w[29:0]);
        mag = mag / (longint'(1) << (6 * (5 - r)));
        mag = mag % (longint'(1) << (6 * (r - lp + 1)));
        return (l == 0 && w[30]) ? -mag : mag;
    endfunction

    function automatic logic [1:0] model_ci(input logic [30:0] a, input logic [30:0] b,
                                            input int l, input int r);
        longint va, vb;
        va = field_val(a, l, r);
        vb = field_val(b, l, r);
        if (va > vb) return 2'b10;
        if (va < vb) return 2'b01;
        return 2'b00;
    endfunction

    function automatic bit legal(input logic [5:0] op, input logic [5:0] f);
        return (op >= 6'd56) && (f[5:3] <= f[2:0]) && (f[2:0] <= 3'd5);
    endfunction

    // Issue one command; optionally pulse a stray start at cycle glitch_at.
    task automatic run_cmd(input logic [5:0] op, input logic [5:0] f, input logic [AW-1:0] a,
                           input int delay, input int glitch_at,
                           output int cyc, output int rd_cycles, output logic flt,
                           output logic addr_ok, output logic seen_done);
        ack_delay = delay;
        @(negedge clk);
        start = 1'b1; opcode = op; fspec = f; addr = a;
        cyc = 0; rd_cycles = 0; flt = 1'b0; addr_ok = 1'b1; seen_done = 1'b0;
        while (!seen_done && cyc < 60) begin
            @(negedge clk);
            cyc++;
            start = 1'b0;
            if (glitch_at > 0 && cyc == glitch_at) begin
                start = 1'b1; opcode = 6'd10; fspec = 6'd5;
            end
            if (mem_rd) begin
                rd_cycles++;
                if (mem_addr !== a) addr_ok = 1'b0;
            end
            if (done) begin
                seen_done = 1'b1;
                flt = fault;
            end
        end
        start = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b1; start = 1'b0; opcode = '0; fspec = '0; addr = '0; ack_delay = 0;
        #1 rst_n = 1'b0;
        repeat (2) @(negedge clk);
        tests_run++;
        if ({busy, done, fault, mem_rd} !== 4'b0000) begin
            tests_failed++;
            $display("FAIL reset_ctrl: got %b expected 0000", {busy, done, fault, mem_rd});
        end
        tests_run++;
        if (reg_sel !== 3'd0 || mem_addr !== '0 || ci !== 2'b00) begin
            tests_failed++;
            $display("FAIL reset_regs: got sel=%0d addr=%0d ci=%b expected 0/0/00", reg_sel, mem_addr, ci);
        end
        rst_n = 1'b1;
        exp_ci = 2'b00;
    endtask

    task automatic test_compare();
        logic [5:0]  t_op  [5] = '{6'd56, 6'd63, 6'd63, 6'd59, 6'd56};
        logic [5:0]  t_f   [5] = '{6'd5, 6'd13, 6'd5, 6'd5, 6'd0};
        logic [30:0] t_reg [5] = '{31'd100, {1'b1, 30'd7}, {1'b1, 30'd7}, {1'b1, 30'd0}, {1'b1, 30'd5}};
        logic [30:0] t_mem [5] = '{31'd99, 31'd7, 31'd7, 31'd0, 31'd9};
        logic [1:0]  t_ci  [5] = '{2'b10, 2'b00, 2'b01, 2'b00, 2'b00};
        int cyc, rdc;
        logic flt, aok, sd;
        for (int i = 0; i < 5; i++) begin
            regs[t_op[i] - 6'd56] = t_reg[i];
            mem[100 + i] = t_mem[i];
            run_cmd(t_op[i], t_f[i], AW'(100 + i), 0, 0, cyc, rdc, flt, aok, sd);
            tests_run++;
            if (!sd || cyc != 5 || flt !== 1'b0) begin
                tests_failed++;
                $display("FAIL cmp_latency[%0d]: got done=%b cyc=%0d fault=%b expected 1/5/0", i, sd, cyc, flt);
            end
            tests_run++;
            if (ci !== t_ci[i]) begin
                tests_failed++;
                $display("FAIL cmp_ci[%0d]: got %b expected %b", i, ci, t_ci[i]);
            end
            exp_ci = t_ci[i];
        end
    endtask

    task automatic test_mem_wait_busy();
        int cyc, rdc;
        logic flt, aok, sd;
        logic seen;
        regs[0] = 31'd3;
        mem[200] = {1'b1, 30'd3};
        run_cmd(6'd56, 6'd5, AW'(200), 3, 2, cyc, rdc, flt, aok, sd);
        exp_ci = 2'b10;
        tests_run++;
        if (!sd || cyc != 8) begin
            tests_failed++;
            $display("FAIL wait_latency: got done=%b cyc=%0d expected 1/8", sd, cyc);
        end
        tests_run++;
        if (rdc != 4 || !aok) begin
            tests_failed++;
            $display("FAIL wait_memrd: got rd_cycles=%0d addr_ok=%b expected 4/1", rdc, aok);
        end
        tests_run++;
        if (ci !== exp_ci) begin
            tests_failed++;
            $display("FAIL wait_ci: got %b expected %b", ci, exp_ci);
        end
        seen = 1'b0;
        repeat (4) begin
            @(negedge clk);
            if (done || busy) seen = 1'b1;
        end
        tests_run++;
        if (seen !== 1'b0) begin
            tests_failed++;
            $display("FAIL busy_ignore: got activity=%b expected 0", seen);
        end
    endtask

    task automatic test_illegal();
        logic [5:0] t_op [3] = '{6'd55, 6'd56, 6'd60};
        logic [5:0] t_f  [3] = '{6'd5, 6'd34, 6'd6};
        int cyc, rdc;
        logic flt, aok, sd;
        for (int i = 0; i < 3; i++) begin
            run_cmd(t_op[i], t_f[i], AW'(300), 0, 0, cyc, rdc, flt, aok, sd);
            tests_run++;
            if (!sd || cyc != 1 || flt !== 1'b1 || rdc != 0) begin
                tests_failed++;
                $display("FAIL illegal[%0d]: got done=%b cyc=%0d fault=%b rd=%0d expected 1/1/1/0",
                         i, sd, cyc, flt, rdc);
            end
            tests_run++;
            if (ci !== exp_ci) begin
                tests_failed++;
                $display("FAIL illegal_ci[%0d]: got %b expected %b", i, ci, exp_ci);
            end
        end
    endtask

    task automatic test_reset_abort();
        int cyc, rdc;
        logic flt, aok, sd;
        regs[0] = {1'b1, 30'd50};
        mem[400] = 31'd1;
        ack_delay = 20;
        @(negedge clk);
        start = 1'b1; opcode = 6'd56; fspec = 6'd5; addr = AW'(400);
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        tests_run++;
        if (mem_rd !== 1'b1) begin
            tests_failed++;
            $display("FAIL abort_fetch: got mem_rd=%b expected 1", mem_rd);
        end
        #2 rst_n = 1'b0;
        #1;
        tests_run++;
        if (mem_rd !== 1'b0 || busy !== 1'b0 || ci !== 2'b00) begin
            tests_failed++;
            $display("FAIL abort_state: got mem_rd=%b busy=%b ci=%b expected 0/0/00", mem_rd, busy, ci);
        end
        @(negedge clk);
        rst_n = 1'b1;
        run_cmd(6'd56, 6'd5, AW'(400), 1, 0, cyc, rdc, flt, aok, sd);
        tests_run++;
        if (!sd || cyc != 6 || ci !== 2'b01) begin
            tests_failed++;
            $display("FAIL abort_recover: got done=%b cyc=%0d ci=%b expected 1/6/01", sd, cyc, ci);
        end
        exp_ci = 2'b01;
    endtask

    task automatic test_back_to_back();
        int cyc, rdc;
        logic flt, aok, sd;
        logic [1:0] e;
        for (int i = 0; i < 3; i++) begin
            regs[7] = 31'($urandom);
            mem[500 + i] = 31'($urandom);
            e = model_ci(rview(7), mem[500 + i], 1, 5);
            run_cmd(6'd63, 6'd13, AW'(500 + i), 0, 0, cyc, rdc, flt, aok, sd);
            tests_run++;
            if (!sd || cyc != 5 || ci !== e) begin
                tests_failed++;
                $display("FAIL b2b[%0d]: got done=%b cyc=%0d ci=%b expected 1/5/%b", i, sd, cyc, ci, e);
            end
            exp_ci = e;
        end
    endtask

    task automatic test_random();
        int cyc, rdc, d, l, r, sel;
        logic flt, aok, sd;
        logic [5:0] op, f;
        logic [AW-1:0] a;
        for (int i = 0; i < 40; i++) begin
            op = ($urandom_range(0, 7) == 0) ? 6'($urandom_range(40, 55)) : 6'($urandom_range(56, 63));
            l = $urandom_range(0, 5);
            r = $urandom_range(l, 5);
            f = 6'(8 * l + r);
            if ($urandom_range(0, 7) == 0) f = 6'($urandom_range(0, 63));
            d = $urandom_range(0, 3);
            a = AW'($urandom_range(600, 4095));
            sel = int'(op[2:0]);
            regs[sel] = 31'($urandom);
            mem[a] = ($urandom_range(0, 3) == 0) ? rview(sel) : 31'($urandom);
            if ($urandom_range(0, 5) == 0) mem[a][29:0] = '0;
            run_cmd(op, f, a, d, 0, cyc, rdc, flt, aok, sd);
            if (legal(op, f)) begin
                exp_ci = model_ci(rview(sel), mem[a], int'(f[5:3]), int'(f[2:0]));
                tests_run++;
                if (!sd || cyc != 5 + d || flt !== 1'b0 || rdc != d + 1 || !aok || ci !== exp_ci) begin
                    tests_failed++;
                    $display("FAIL rand[%0d]: op=%0d f=%0d got done=%b cyc=%0d fault=%b rd=%0d ci=%b expected 1/%0d/0/%0d/%b",
                             i, op, f, sd, cyc, flt, rdc, ci, 5 + d, d + 1, exp_ci);
                end
            end else begin
                tests_run++;
                if (!sd || cyc != 1 || flt !== 1'b1 || rdc != 0 || ci !== exp_ci) begin
                    tests_failed++;
                    $display("FAIL rand_illegal[%0d]: op=%0d f=%0d got done=%b cyc=%0d fault=%b ci=%b expected 1/1/1/%b",
                             i, op, f, sd, cyc, flt, ci, exp_ci);
                end
            end
        end
    endtask

    initial begin
        tests_run = 0;
        tests_failed = 0;
        for (int i = 0; i < 8; i++) regs[i] = '0;
        test_reset();
        test_compare();
        test_mem_wait_busy();
        test_illegal();
        test_reset_abort();
        test_back_to_back();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
